load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and memory bus bundle for the load/store unit.
// slave = the unit itself, master = pipeline plus memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        store_enable;
  logic [3:0]  mem_write_enable;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, store_enable, mem_write_enable,
    input  func3, addr, wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rdata, err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, store_enable, mem_write_enable,
    output func3, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rdata, err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane alignment, extension, misalignment checks.
// One outstanding memory access; IDLE -> ACCESS -> RESP.
module load_store_unit (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic        we_q;
  logic [1:0]  off_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q;

  logic        accept;
  logic        illegal;
  logic        ack;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;

  logic        req_ready;
  logic        rsp_valid;
  logic        mem_req;
  logic        mem_we;

  assign accept = (state_q == S_IDLE) && bus.req_valid;
  assign ack    = (state_q == S_ACCESS) && bus.mem_ack;

  always_comb begin
    illegal = 1'b0;
    if (bus.func3[1:0] == 2'b11)
      illegal = 1'b1;
    if (!bus.store_enable &&
        (bus.func3 == 3'b011 ||
         bus.func3 == 3'b110 ||
         bus.func3 == 3'b111))
      illegal = 1'b1;
    if (bus.store_enable && bus.func3[2])
      illegal = 1'b1;
    if (bus.func3[1:0] == 2'b01 && bus.addr[0])
      illegal = 1'b1;
    if (bus.func3[1:0] == 2'b10 &&
        bus.addr[1:0] != 2'b00)
      illegal = 1'b1;
    if (bus.store_enable &&
        bus.mem_write_enable == 4'b0000)
      illegal = 1'b1;
  end

  // Lane placement happens once at accept so the bus stays stable.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    if (bus.store_enable) begin
      be_d    = bus.mem_write_enable << bus.addr[1:0];
      wdata_d = bus.wdata << {bus.addr[1:0], 3'b000};
    end else begin
      unique case (bus.func3[1:0])
        2'b00:   be_d = 4'b0001 << bus.addr[1:0];
        2'b01:   be_d = 4'b0011 << bus.addr[1:0];
        default: be_d = 4'b1111;
      endcase
    end
  end

  always_comb begin
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    rdata_d = 32'h0;
    if (!we_q) begin
      unique case (func3_q)
        3'b000:  rdata_d = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  rdata_d = {{16{shifted[15]}}, shifted[15:0]};
        3'b100:  rdata_d = {24'h0, shifted[7:0]};
        3'b101:  rdata_d = {16'h0, shifted[15:0]};
        default: rdata_d = shifted;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.req_valid)
          state_d = illegal ? S_RESP : S_ACCESS;
      S_ACCESS:
        if (bus.mem_ack) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE:   req_ready = 1'b1;
      S_ACCESS: begin
        mem_req = 1'b1;
        mem_we  = we_q;
      end
      S_RESP:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      off_q   <= 2'b00;
      func3_q <= 3'b000;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.store_enable;
      off_q   <= bus.addr[1:0];
      func3_q <= bus.func3;
      addr_q  <= {bus.addr[31:2], 2'b00};
      be_q    <= be_d;
      wdata_q <= wdata_d;
      if (illegal) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end
    end else if (ack) begin
      err_q   <= 1'b0;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: responses checked against
// expectations queued when each request is driven.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] sb[$];

  load_store_unit_if bus();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rdata", bus.rdata, e[31:0]);
        chk("err", {31'h0, bus.err}, {31'h0, e[32]});
      end
    end
  end

  task automatic do_op(input logic        st,
                       input logic [3:0]  mwe,
                       input logic [2:0]  f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] rw,
                       input int          dly,
                       input logic [31:0] exp_rd,
                       input logic        exp_err,
                       input logic [3:0]  exp_be,
                       input logic [31:0] exp_wd);
    @(negedge clk);
    chk("req_ready", {31'h0, bus.req_ready}, 32'd1);
    bus.req_valid        = 1'b1;
    bus.store_enable     = st;
    bus.mem_write_enable = mwe;
    bus.func3            = f3;
    bus.addr             = a;
    bus.wdata            = wd;
    sb.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.wdata = $urandom;
    if (exp_err) begin
      @(negedge clk);
      chk("err_rsp", {31'h0, bus.rsp_valid}, 32'd1);
      chk("err_noreq", {31'h0, bus.mem_req}, 32'd0);
      @(negedge clk);
      chk("err_noreq2", {31'h0, bus.mem_req}, 32'd0);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        @(negedge clk);
        chk("mem_req", {31'h0, bus.mem_req}, 32'd1);
        chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        chk("mem_be", {28'h0, bus.mem_be}, {28'h0, exp_be});
        chk("mem_we", {31'h0, bus.mem_we}, {31'h0, st});
        if (st)
          chk("mem_wdata", bus.mem_wdata, exp_wd);
        if (i == dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rw;
        end
      end
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("rsp_lat", {31'h0, bus.rsp_valid}, 32'd1);
      chk("req_drop", {31'h0, bus.mem_req}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid        = 1'b0;
    bus.store_enable     = 1'b0;
    bus.mem_write_enable = 4'b0000;
    bus.func3            = 3'b000;
    bus.addr             = 32'h0;
    bus.wdata            = 32'h0;
    bus.mem_ack          = 1'b0;
    bus.mem_rdata        = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("rst_req", {31'h0, bus.mem_req}, 32'd0);
    chk("rst_rsp", {31'h0, bus.rsp_valid}, 32'd0);
    chk("rst_be", {28'h0, bus.mem_be}, 32'd0);

    // st mwe f3 addr wdata mem_rdata dly exp_rd err exp_be exp_wd
    do_op(1, 4'b0001, 3'b000, 32'h103, 32'hAB, 0, 1,
          0, 0, 4'b1000, 32'hAB00_0000);
    do_op(0, 4'b0000, 3'b001, 32'h202, 0, 32'h8001_1234, 0,
          32'hFFFF_8001, 0, 4'b1100, 0);
    do_op(0, 4'b0000, 3'b101, 32'h202, 0, 32'h8001_1234, 2,
          32'h0000_8001, 0, 4'b1100, 0);
    do_op(0, 4'b0000, 3'b000, 32'h201, 0, 32'h8001_1234, 0,
          32'h0000_0012, 0, 4'b0010, 0);
    do_op(0, 4'b0000, 3'b010, 32'h6, 0, 0, 0,
          0, 1, 0, 0);
    do_op(1, 4'b1111, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0,
          0, 0, 4'b1111, 32'hDEAD_BEEF);
    do_op(0, 4'b0000, 3'b000, 32'h203, 0, 32'h80FF_FFFF, 0,
          32'hFFFF_FF80, 0, 4'b1000, 0);
    do_op(0, 4'b0000, 3'b100, 32'h203, 0, 32'h80FF_FFFF, 1,
          32'h0000_0080, 0, 4'b1000, 0);
    do_op(0, 4'b0000, 3'b011, 32'h20, 0, 0, 0,
          0, 1, 0, 0);
    do_op(1, 4'b0000, 3'b000, 32'h20, 32'h55, 0, 0,
          0, 1, 0, 0);
    do_op(1, 4'b0001, 3'b100, 32'h20, 32'h55, 0, 0,
          0, 1, 0, 0);
    do_op(1, 4'b0011, 3'b001, 32'h21, 32'h55, 0, 0,
          0, 1, 0, 0);
    do_op(1, 4'b0011, 3'b001, 32'h22, 32'h1234_ABCD, 0, 3,
          0, 0, 4'b1100, 32'hABCD_0000);
    do_op(0, 4'b0000, 3'b010, 32'h3C, 0, 32'h1122_3344, 2,
          32'h1122_3344, 0, 4'b1111, 0);

    // Reset while a load is in flight, then a stray ack.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.store_enable = 1'b0;
    bus.func3        = 3'b010;
    bus.addr         = 32'h40;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'h0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {31'h0, bus.mem_req}, 32'd0);
    chk("mid_rst_rsp", {31'h0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_rdata", bus.rdata, 32'd0);
    chk("mid_rst_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_be", {28'h0, bus.mem_be}, 32'd0);
    chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
    chk("mid_rst_err", {31'h0, bus.err}, 32'd0);
    chk("mid_rst_ready", {31'h0, bus.req_ready}, 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_ack_rdata", bus.rdata, 32'd0);

    do_op(0, 4'b0000, 3'b101, 32'h52, 0, 32'hBEEF_0000, 1,
          32'h0000_BEEF, 0, 4'b1100, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
